// File: rtl/filt_peak_meter.sv
`default_nettype none
// ============================================================================
// Module      : filt_peak_meter
// Description : Peak meter for a signed 1s17 filter output. After a settling
//               flush, it measures max, min, peak-to-peak and full-scale clip
//               count over back-to-back windows of 2^WIN_LOG2 accepted
//               samples, and strobes meas_valid when a window completes.
// Revision    : 1.0 - initial release
// ============================================================================
module filt_peak_meter #(
  parameter int WIN_LOG2  = 10,
  parameter int FLUSH_LEN = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [17:0]         y_in,
  input  logic                       in_valid,
  output logic signed [17:0]         pk_max,
  output logic signed [17:0]         pk_min,
  output logic        [18:0]         pk2pk,
  output logic        [WIN_LOG2:0]   clip_cnt,
  output logic                       meas_valid,
  output logic                       meas_active
);

  // Flush counter is sized for at least one bit so FLUSH_LEN of 0 or 1 stays legal.
  localparam int                     c_FCW        = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [c_FCW-1:0]       c_FLUSH_LAST = (FLUSH_LEN > 0) ? c_FCW'(FLUSH_LEN - 1) : '0;
  localparam logic [WIN_LOG2-1:0]    c_WIN_LAST   = '1;
  localparam logic signed [17:0]     c_FS_POS     = 18'sh1FFFF;
  localparam logic signed [17:0]     c_FS_NEG     = 18'sh20000;

  typedef enum logic [0:0] {
    S_FLUSH   = 1'b0,
    S_MEASURE = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [c_FCW-1:0]         r_flush_cnt;
  logic [WIN_LOG2-1:0]      r_win_cnt;
  logic signed [17:0]       r_run_max;
  logic signed [17:0]       r_run_min;
  logic [WIN_LOG2:0]        r_run_clip;

  logic signed [17:0]       r_pk_max;
  logic signed [17:0]       r_pk_min;
  logic [18:0]              r_pk2pk;
  logic [WIN_LOG2:0]        r_clip_cnt;
  logic                     r_meas_valid;

  logic                     w_accept;
  logic                     w_first;
  logic                     w_last;
  logic                     w_is_clip;
  logic signed [17:0]       w_new_max;
  logic signed [17:0]       w_new_min;
  logic [WIN_LOG2:0]        w_new_clip;
  logic [18:0]              w_p2p;

  // State register: reset always lands in FLUSH.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FLUSH;
    else       r_state <= w_next;
  end

  // Next state: FLUSH ends on the last flush sample, or immediately when no flush is configured.
  always_comb begin
    w_next      = r_state;
    meas_active = 1'b0;
    case (r_state)
      S_FLUSH: begin
        if (FLUSH_LEN == 0)
          w_next = S_MEASURE;
        else if (in_valid && (r_flush_cnt == c_FLUSH_LAST))
          w_next = S_MEASURE;
      end
      S_MEASURE: begin
        meas_active = 1'b1;
      end
      default: w_next = S_FLUSH;
    endcase
  end

  // Flush sample counter; samples are only counted, never used.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush_cnt <= '0;
    end else if ((r_state == S_FLUSH) && in_valid && (FLUSH_LEN != 0)) begin
      if (r_flush_cnt == c_FLUSH_LAST) r_flush_cnt <= '0;
      else                             r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  // Running statistics including the current sample; sample 0 restarts the window.
  always_comb begin
    w_accept   = in_valid && (r_state == S_MEASURE);
    w_first    = (r_win_cnt == '0);
    w_last     = (r_win_cnt == c_WIN_LAST);
    w_is_clip  = (y_in == c_FS_POS) || (y_in == c_FS_NEG);
    w_new_max  = (w_first || (y_in > r_run_max)) ? y_in : r_run_max;
    w_new_min  = (w_first || (y_in < r_run_min)) ? y_in : r_run_min;
    w_new_clip = (w_first ? '0 : r_run_clip) + {{WIN_LOG2{1'b0}}, w_is_clip};
    // Sign-extend both to 19 bits; max >= min so the difference is never negative.
    w_p2p      = {w_new_max[17], w_new_max} - {w_new_min[17], w_new_min};
  end

  // Window accumulation and result registers; results latch on the last sample of a window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_cnt    <= '0;
      r_run_max    <= '0;
      r_run_min    <= '0;
      r_run_clip   <= '0;
      r_pk_max     <= '0;
      r_pk_min     <= '0;
      r_pk2pk      <= '0;
      r_clip_cnt   <= '0;
      r_meas_valid <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      if (w_accept) begin
        r_win_cnt  <= r_win_cnt + 1'b1;
        r_run_max  <= w_new_max;
        r_run_min  <= w_new_min;
        r_run_clip <= w_new_clip;
        if (w_last) begin
          r_pk_max     <= w_new_max;
          r_pk_min     <= w_new_min;
          r_pk2pk      <= w_p2p;
          r_clip_cnt   <= w_new_clip;
          r_meas_valid <= 1'b1;
        end
      end
    end
  end

  assign pk_max     = r_pk_max;
  assign pk_min     = r_pk_min;
  assign pk2pk      = r_pk2pk;
  assign clip_cnt   = r_clip_cnt;
  assign meas_valid = r_meas_valid;

endmodule
`default_nettype wire

// File: doc/filt_peak_meter.md
FILT_PEAK_METER -- requirements
Module: filt_peak_meter

Interface
REQ-001 The block SHALL have parameter WIN_LOG2, default 10, giving the log2 of the measurement window length in accepted samples (N = 2^WIN_LOG2).
REQ-002 The block SHALL have parameter FLUSH_LEN, default 32, giving the number of accepted samples discarded after reset while the upstream filter pipeline settles.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port y_in, input, 18 bits: signed 1s17 filter output sample.
REQ-006 The block SHALL have port in_valid, input, 1 bit: high means y_in is accepted on this edge.
REQ-007 The block SHALL have port pk_max, output, 18 bits: signed maximum of the last completed window.
REQ-008 The block SHALL have port pk_min, output, 18 bits: signed minimum of the last completed window.
REQ-009 The block SHALL have port pk2pk, output, 19 bits: unsigned pk_max minus pk_min.
REQ-010 The block SHALL have port clip_cnt, output, WIN_LOG2+1 bits: count of full-scale samples in the last completed window.
REQ-011 The block SHALL have port meas_valid, output, 1 bit: one-cycle strobe marking updated results.
REQ-012 The block SHALL have port meas_active, output, 1 bit: high while in state MEASURE.

Function
REQ-013 The FSM SHALL have two states, FLUSH and MEASURE, and SHALL enter FLUSH on reset.
REQ-014 In FLUSH, the block SHALL count accepted samples and discard them.
REQ-015 On the edge accepting flush sample FLUSH_LEN-1, the FSM SHALL move to MEASURE; with FLUSH_LEN=0 it SHALL move to MEASURE on the first edge after reset deasserts, without consuming a sample.
REQ-016 In MEASURE, the window counter SHALL advance 0..N-1 on each accepted sample and wrap to 0.
REQ-017 Sample 0 of a window SHALL load running max and running min with y_in; later samples SHALL update them by signed comparison.
REQ-018 A sample SHALL be counted as a clip when y_in equals +131071 or -131072; the running clip count SHALL restart at sample 0 of each window.
REQ-019 On the edge accepting sample N-1, the block SHALL register pk_max, pk_min, pk2pk and clip_cnt including that sample, and SHALL drive meas_valid high for exactly that following cycle.
REQ-020 pk2pk SHALL be computed at 19 bits with range 0..262143 and no overflow or saturation.
REQ-021 clip_cnt SHALL have range 0..N and SHALL not wrap.
REQ-022 Windows SHALL be back-to-back: the next accepted sample after N-1 SHALL be sample 0 of the next window.
REQ-023 When in_valid is low, all counters, running values, outputs and state SHALL hold, except that meas_valid SHALL return low.
REQ-024 Outputs other than meas_valid SHALL hold their values between strobes.

Reset
REQ-025 reset SHALL take priority over in_valid on every edge.
REQ-026 While reset is high, pk_max, pk_min, pk2pk, clip_cnt, meas_valid and meas_active SHALL be 0, all counters SHALL be 0, and the state SHALL be FLUSH.
REQ-027 Reset mid-window SHALL discard the partial window with no meas_valid, and the flush SHALL repeat in full after reset is released.

Verification (WIN_LOG2=4, FLUSH_LEN=32 unless stated)
REQ-028 Scenario 1: reset, then constant y_in=1000 with in_valid=1 -> first meas_valid after the 48th accepted sample; pk_max=1000, pk_min=1000, pk2pk=0, clip_cnt=0; a second strobe follows exactly 16 cycles later.
REQ-029 Scenario 2: after flush, ramp -8..7 over one window -> pk_max=7, pk_min=-8, pk2pk=15, clip_cnt=0.
REQ-030 Scenario 3: alternating 131071/-131072 for one window -> pk_max=131071, pk_min=-131072, pk2pk=262143, clip_cnt=16.
REQ-031 Scenario 4: in_valid toggled every other cycle with the ramp of scenario 2 -> meas_valid only after 16 accepted samples (about 32 cycles) with results identical to scenario 2, and meas_valid is never high for more than one cycle.
REQ-032 Scenario 5: reset asserted for 1 cycle at window sample 8 -> all outputs 0 on the next edge, no meas_valid; the next strobe arrives 48 accepted samples after reset is released.
REQ-033 Scenario 6: FLUSH_LEN=0 with constant input -5 -> meas_active high one cycle after reset is released; first meas_valid after 16 accepted samples; pk_max=pk_min=-5.
